// File: rtl/pc_ctrl.sv
// PC redirect controller: arbitrates trap/mret/branch redirects against fetch
// readiness, holds targets while the ibus is busy, and drives flush/WFI sleep.
module pc_ctrl #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_ready,
    input  logic        hazard_stall,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        mret_req,
    input  logic [31:0] mret_pc,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        wfi_req,
    input  logic        irq_pending,
    output logic        stall_fetch,
    output logic        next_pc_en,
    output logic [31:0] next_pc,
    output logic        flush,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2,
        WFI   = 2'd3
    } state_e;

    localparam logic [2:0] CNT_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam state_e     ACCEPT_ST = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pending_q, pending_d;

    logic        any_req;
    logic [31:0] sel_target;
    logic        take_req;
    logic [31:0] take_tgt;
    logic        stall_c, en_c, flush_c;
    logic [31:0] tgt_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 3'd0;
            pending_q <= RESET_ADDR;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        any_req    = trap_req | mret_req | br_req;
        sel_target = trap_req ? trap_vec : (mret_req ? mret_pc : br_target);

        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        take_req  = 1'b0;
        take_tgt  = sel_target;
        stall_c   = 1'b0;
        en_c      = 1'b0;
        flush_c   = 1'b0;
        tgt_c     = pending_q;

        case (state_q)
            RUN: begin
                take_req = any_req;
                if (!any_req) begin
                    stall_c = hazard_stall | ~ibus_ready;
                    if (wfi_req && !irq_pending) state_d = WFI;
                end
            end
            HOLD: begin
                flush_c = 1'b1;
                stall_c = ~ibus_ready;
                if (trap_req) pending_d = trap_vec;
                if (ibus_ready) begin
                    en_c    = 1'b1;
                    tgt_c   = trap_req ? trap_vec : pending_q;
                    state_d = ACCEPT_ST;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                flush_c  = 1'b1;
                stall_c  = ~ibus_ready;
                take_req = trap_req;
                take_tgt = trap_vec;
                if (!trap_req) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = RUN;
                end
            end
            default: begin // WFI
                stall_c  = 1'b1;
                take_req = trap_req;
                take_tgt = trap_vec;
                if (!trap_req && irq_pending) state_d = RUN;
            end
        endcase

        // A redirect accepted from RUN, FLUSH or WFI shares one issue/park path.
        if (take_req) begin
            flush_c = 1'b1;
            if (ibus_ready) begin
                en_c    = 1'b1;
                tgt_c   = take_tgt;
                stall_c = 1'b0;
                state_d = ACCEPT_ST;
                cnt_d   = CNT_LOAD;
            end else begin
                pending_d = take_tgt;
                stall_c   = 1'b1;
                en_c      = 1'b0;
                state_d   = HOLD;
            end
        end
    end

    // Outputs are combinational on inputs, so reset must override them directly.
    always_comb begin
        if (rst) begin
            stall_fetch = 1'b1;
            next_pc_en  = 1'b0;
            flush       = 1'b1;
            next_pc     = RESET_ADDR;
            state       = RUN;
        end else begin
            stall_fetch = stall_c;
            next_pc_en  = en_c;
            flush       = flush_c;
            next_pc     = en_c ? tgt_c : pending_q;
            state       = state_q;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: per-cycle vector table plus hand sequences for
// long WFI sleep and asynchronous reset during FLUSH.
module tb_pc_ctrl;

    localparam logic [31:0] RA = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_ready, hazard_stall, trap_req, mret_req, br_req, wfi_req, irq_pending;
    logic [31:0] trap_vec, mret_pc, br_target;
    logic        stall_fetch, next_pc_en, flush;
    logic [31:0] next_pc;
    logic [1:0]  state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pc_ctrl #(.RESET_ADDR(RA), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ibus_ready(ibus_ready), .hazard_stall(hazard_stall),
        .trap_req(trap_req), .trap_vec(trap_vec), .mret_req(mret_req), .mret_pc(mret_pc),
        .br_req(br_req), .br_target(br_target), .wfi_req(wfi_req), .irq_pending(irq_pending),
        .stall_fetch(stall_fetch), .next_pc_en(next_pc_en), .next_pc(next_pc),
        .flush(flush), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trap;
        logic [31:0] tvec;
        logic        mret;
        logic [31:0] mpc;
        logic        br;
        logic [31:0] btgt;
        logic        rdy;
        logic        hz;
        logic        wfi;
        logic        irq;
        logic        e_stall;
        logic        e_en;
        logic [31:0] e_npc;
        logic        e_flush;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic trap, logic [31:0] tvec, logic mret, logic [31:0] mpc,
                                logic br, logic [31:0] btgt, logic rdy, logic hz, logic wfi,
                                logic irq, logic e_stall, logic e_en, logic [31:0] e_npc,
                                logic e_flush, logic [1:0] e_state);
        vec_t v;
        v.trap = trap; v.tvec = tvec; v.mret = mret; v.mpc = mpc; v.br = br; v.btgt = btgt;
        v.rdy = rdy; v.hz = hz; v.wfi = wfi; v.irq = irq; v.e_stall = e_stall; v.e_en = e_en;
        v.e_npc = e_npc; v.e_flush = e_flush; v.e_state = e_state;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic e_stall, input logic e_en,
                           input logic [31:0] e_npc, input logic e_flush, input logic [1:0] e_state);
        chk({tag, ".stall"}, 32'(stall_fetch), 32'(e_stall));
        chk({tag, ".en"},    32'(next_pc_en),  32'(e_en));
        chk({tag, ".npc"},   next_pc,          e_npc);
        chk({tag, ".flush"}, 32'(flush),       32'(e_flush));
        chk({tag, ".state"}, 32'(state),       32'(e_state));
    endtask

    task automatic drive(input logic trap, input logic [31:0] tvec, input logic mret,
                         input logic [31:0] mpc, input logic br, input logic [31:0] btgt,
                         input logic rdy, input logic hz, input logic wfi, input logic irq);
        trap_req = trap; trap_vec = tvec; mret_req = mret; mret_pc = mpc; br_req = br;
        br_target = btgt; ibus_ready = rdy; hazard_stall = hz; wfi_req = wfi; irq_pending = irq;
    endtask

    task automatic idle(input logic rdy, input logic wfi, input logic irq);
        drive(0, 0, 0, 0, 0, 0, rdy, 0, wfi, irq);
    endtask

    initial begin
        // trap tvec mret mpc br btgt rdy hz wfi irq | stall en npc flush state
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,RA,      0,0)); // 0 idle
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,1,0,0, 1,0,RA,      0,0)); // 1 hazard
        tbl.push_back(mk(0,0,   0,0,    0,0,    0,0,0,0, 1,0,RA,      0,0)); // 2 not ready
        tbl.push_back(mk(0,0,   0,0,    1,'h100,1,0,0,0, 0,1,'h100,   1,0)); // 3 branch
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,1,0,0, 0,0,RA,      1,2)); // 4 flush, hz ignored
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,RA,      0,0)); // 5 back in RUN
        tbl.push_back(mk(1,'h80,1,'h400,1,'h200,1,0,0,0, 0,1,'h80,    1,0)); // 6 trap wins
        tbl.push_back(mk(0,0,   0,0,    1,'h500,0,0,0,0, 1,0,RA,      1,2)); // 7 br in FLUSH dropped
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,RA,      0,0)); // 8
        tbl.push_back(mk(0,0,   1,'h400,1,'h200,1,0,0,0, 0,1,'h400,   1,0)); // 9 mret over br
        tbl.push_back(mk(1,'h90,0,0,    0,0,    1,0,0,0, 0,1,'h90,    1,2)); // 10 trap in FLUSH
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,RA,      1,2)); // 11 counter reloaded
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,RA,      0,0)); // 12
        tbl.push_back(mk(0,0,   0,0,    1,'h300,0,0,0,0, 1,0,RA,      1,0)); // 13 park branch
        tbl.push_back(mk(1,'h80,0,0,    0,0,    0,0,0,0, 1,0,'h300,   1,1)); // 14 trap overwrites
        tbl.push_back(mk(0,0,   0,0,    1,'h700,0,0,0,0, 1,0,'h80,    1,1)); // 15 br ignored in HOLD
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,1,'h80,    1,1)); // 16 release held
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,'h80,    1,2)); // 17
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,'h80,    0,0)); // 18
        tbl.push_back(mk(0,0,   0,0,    1,'h240,1,0,1,0, 0,1,'h240,   1,0)); // 19 redirect beats wfi
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,'h80,    1,2)); // 20
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,'h80,    0,0)); // 21
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,1,1, 0,0,'h80,    0,0)); // 22 wfi with irq
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,'h80,    0,0)); // 23 still RUN
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,1,0, 0,0,'h80,    0,0)); // 24 enter WFI
        tbl.push_back(mk(0,0,   0,0,    1,'h500,1,0,0,0, 1,0,'h80,    0,3)); // 25 br ignored in WFI
        tbl.push_back(mk(1,'h88,0,0,    0,0,    1,0,0,0, 0,1,'h88,    1,3)); // 26 trap wakes
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,'h80,    1,2)); // 27
        tbl.push_back(mk(0,0,   0,0,    0,0,    1,0,0,0, 0,0,'h80,    0,0)); // 28

        rst = 1'b1;
        idle(1, 0, 0);
        #12;
        chk_all("reset", 1, 0, RA, 1, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].trap, tbl[i].tvec, tbl[i].mret, tbl[i].mpc, tbl[i].br, tbl[i].btgt,
                  tbl[i].rdy, tbl[i].hz, tbl[i].wfi, tbl[i].irq);
            #2;
            chk_all($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_en, tbl[i].e_npc,
                    tbl[i].e_flush, tbl[i].e_state);
            @(negedge clk);
        end

        // Long WFI sleep, then wake on interrupt.
        idle(1, 1, 0);
        #2;
        chk_all("wfi_enter", 0, 0, 32'h80, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            idle(1, 0, 0);
            #2;
            chk_all($sformatf("wfi_sleep%0d", i), 1, 0, 32'h80, 0, 3);
            @(negedge clk);
        end
        idle(1, 0, 1);
        #2;
        chk_all("wfi_irq", 1, 0, 32'h80, 0, 3);
        @(negedge clk);
        idle(1, 0, 0);
        #2;
        chk_all("wfi_woke", 0, 0, 32'h80, 0, 0);
        @(negedge clk);

        // Asynchronous reset pulse in the middle of FLUSH.
        drive(0, 0, 0, 0, 1, 32'h140, 1, 0, 0, 0);
        #2;
        chk_all("rst_br", 0, 1, 32'h140, 1, 0);
        @(negedge clk);
        idle(1, 0, 0);
        #2;
        chk_all("rst_inflush", 0, 0, 32'h80, 1, 2);
        rst = 1'b1;
        #1;
        chk_all("rst_async", 1, 0, RA, 1, 0);
        #1;
        rst = 1'b0;
        #1;
        chk_all("rst_release", 0, 0, RA, 0, 0);
        @(negedge clk);
        #2;
        chk_all("rst_after", 0, 0, RA, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_ADDR, default DEFAULT_RESET_ADDR, value loaded into the pending-target register on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7, number of cycles flush is asserted per accepted redirect, counting the accept cycle.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 ibus_ready  input  1  fetch memory accepts a new address this cycle.
REQ-006 hazard_stall  input  1  decode hazard stall request.
REQ-007 trap_req, trap_vec  input  1, 32  trap redirect request and target.
REQ-008 mret_req, mret_pc  input  1, 32  trap-return redirect request and target.
REQ-009 br_req, br_target  input  1, 32  taken branch/jump redirect request and target.
REQ-010 wfi_req  input  1  WFI instruction retiring.
REQ-011 irq_pending  input  1  enabled interrupt pending.
REQ-012 stall_fetch  output  1  holds the PC register.
REQ-013 next_pc_en  output  1  selects next_pc over PC+4.
REQ-014 next_pc  output  32  redirect target.
REQ-015 flush  output  1  squashes wrong-path instructions in Decode and Execute.
REQ-016 state  output  2  FSM state: RUN=0, HOLD=1, FLUSH=2, WFI=3.

Function
REQ-017 The redirect priority SHALL be fixed: trap > mret > branch; sel_target is the target of the highest-priority asserted request.
REQ-018 In RUN with any request and ibus_ready=1: next_pc_en=1, next_pc=sel_target, stall_fetch=0, flush=1; next state is FLUSH, or RUN if FLUSH_CYCLES=1.
REQ-019 In RUN with any request and ibus_ready=0: pending<=sel_target, stall_fetch=1, next_pc_en=0, flush=1; next state is HOLD.
REQ-020 In HOLD: flush=1, stall_fetch=!ibus_ready; trap_req overwrites pending with trap_vec; mret_req and br_req are ignored.
REQ-021 In HOLD with ibus_ready=1: next_pc_en=1, next_pc=pending, or trap_vec if trap_req is asserted in the same cycle; next state is FLUSH, or RUN if FLUSH_CYCLES=1.
REQ-022 On leaving RUN or HOLD with a redirect, the counter SHALL load FLUSH_CYCLES-1 (3-bit counter); in FLUSH, flush=1 and the counter decrements each cycle, and the block returns to RUN when the counter reaches 1 on the clock edge.
REQ-023 In FLUSH: stall_fetch=!ibus_ready; hazard_stall, mret_req and br_req are ignored; trap_req restarts the redirect per REQ-018/REQ-019 and reloads the counter.
REQ-024 In RUN with no request: stall_fetch=hazard_stall|!ibus_ready, next_pc_en=0, flush=0.
REQ-025 In RUN with wfi_req=1, no redirect request and irq_pending=0: next state is WFI; a redirect request in the same cycle SHALL win over wfi_req.
REQ-026 In WFI: stall_fetch=1, flush=0, next_pc_en=0.
REQ-027 In WFI, irq_pending=1 with no trap_req SHALL return to RUN on the next edge; trap_req is accepted per REQ-018/REQ-019.
REQ-028 next_pc SHALL be driven to pending whenever next_pc_en=0.
REQ-029 next_pc SHALL be passed through unmodified: no alignment or arithmetic.

Reset
REQ-030 While rst=1: state=RUN, counter=0, pending=RESET_ADDR, stall_fetch=1, next_pc_en=0, flush=1, next_pc=RESET_ADDR.
REQ-031 Reset asserted mid-HOLD, mid-FLUSH or mid-WFI SHALL abandon the operation immediately, with no redirect issued after deassertion.
REQ-032 On the first cycle after deassertion the block SHALL be in RUN, and outputs follow REQ-024.

Verification
REQ-033 RUN, ibus_ready=1, br_req=1, br_target=0x100 -> same cycle next_pc_en=1, next_pc=0x100, flush=1 for 2 cycles, state RUN on the third cycle.
REQ-034 trap_req (trap_vec=0x80) and br_req (0x200) in the same cycle -> next_pc=0x80, and the branch is dropped.
REQ-035 br_req (0x300) with ibus_ready=0 for 3 cycles, and trap_req (0x80) in the second cycle -> state HOLD; on ready, next_pc=0x80 and stall_fetch=0.
REQ-036 wfi_req=1, irq_pending=0 -> state WFI, stall_fetch=1 held 10 cycles; irq_pending=1 -> RUN next cycle.
REQ-037 rst pulsed asynchronously (mid-cycle) during FLUSH -> outputs reach reset values before the next edge; after release, state=RUN, flush=0 and no stale redirect.
